// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the serial adder word path
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial full adder with synchronous active-high carry clear
module serial_adder (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic sum
);

  logic carry;

  assign sum = a ^ b ^ carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
    end else begin
      carry <= (a & b) | (a & carry) | (b & carry);
    end
  end

endmodule

// File: rtl/serial_word_adder.sv
// rtl/serial_word_adder.sv - word-level adder built from the sequencer and serial_adder
module serial_word_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  logic ser_clear;
  logic ser_a;
  logic ser_b;
  logic ser_sum;

  serial_adder_word_sequencer #(.WIDTH(WIDTH)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_clear (ser_clear),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_sum   (ser_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  serial_adder u_add (
    .clk (clk),
    .rst (ser_clear),
    .a   (ser_a),
    .b   (ser_b),
    .sum (ser_sum)
  );

endmodule

// File: rtl/serial_adder_word_sequencer.sv
// rtl/serial_adder_word_sequencer.sv - feeds word operands LSB-first to a serial adder
// and collects the WIDTH+1-bit sum back into a parallel result.
module serial_adder_word_sequencer
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_clear,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  seq_state_t      state;
  seq_state_t      next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH:0]   res;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs depend only on registered state, never on in_valid/out_ready.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ser_clear  = 1'b1;
    ser_a      = 1'b0;
    ser_b      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        ser_clear = 1'b0;
        if (cnt != LAST_CNT) begin
          ser_a = a_sr[0];
          ser_b = b_sr[0];
        end else begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The final SHIFT cycle feeds zeros so the returned bit is the carry-out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr <= in_a;
            b_sr <= in_b;
            res  <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          res  <= {ser_sum, res[WIDTH:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sum = res;

endmodule

// File: tb/tb_serial_adder_word_sequencer.sv
// tb/tb_serial_adder_word_sequencer.sv - directed self-checking bench for the word sequencer
module tb_serial_adder_word_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             ser_clear;
  logic             ser_a;
  logic             ser_b;
  logic             ser_sum;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH:0]   out_sum;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] seq_a;
  logic [WIDTH:0] seq_b;
  logic           last_sa;
  logic           last_sb;
  logic           last_sum;

  always #5 clk = ~clk;

  serial_adder_word_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_clear (ser_clear),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_sum   (ser_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  serial_adder u_add (
    .clk (clk),
    .rst (ser_clear),
    .a   (ser_a),
    .b   (ser_b),
    .sum (ser_sum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair and walk through SHIFT, ending at the first DONE cycle.
  task automatic shift_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      check({tag, "_no_valid_yet"}, {31'd0, out_valid}, 32'd0);
      seq_a[i] = ser_a;
      seq_b[i] = ser_b;
      last_sa  = ser_a;
      last_sb  = ser_b;
      last_sum = ser_sum;
      @(negedge clk);
    end
    check({tag, "_valid_at_9"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic take_result(input logic [WIDTH:0] exp, input string tag);
    check({tag, "_sum"}, {23'd0, out_sum}, {23'd0, exp});
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #12;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ser_clear", {31'd0, ser_clear}, 32'd1);
    check("reset_ser_ab", {30'd0, ser_a, ser_b}, 32'd0);
    check("reset_out_sum", {23'd0, out_sum}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    shift_word(8'h03, 8'h05, "t1");
    take_result(9'h008, "t1");

    shift_word(8'hFF, 8'h01, "t2");
    check("t2_last_ser_ab", {30'd0, last_sa, last_sb}, 32'd0);
    check("t2_last_ser_sum", {31'd0, last_sum}, 32'd1);
    take_result(9'h100, "t2");

    shift_word(8'hFF, 8'hFF, "t3a");
    take_result(9'h1FE, "t3a");
    shift_word(8'h00, 8'h00, "t3b");
    take_result(9'h000, "t3b");

    shift_word(8'hA5, 8'h5A, "t4");
    check("t4_ser_a_seq", {23'd0, seq_a}, 32'h0A5);
    check("t4_ser_b_seq", {23'd0, seq_b}, 32'h05A);
    take_result(9'h0FF, "t4");

    shift_word(8'h11, 8'h22, "t5");
    in_valid = 1'b1;
    in_a     = 8'h44;
    in_b     = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t5_hold_sum", {23'd0, out_sum}, 32'h033);
      check("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    take_result(9'h033, "t5");
    @(negedge clk);
    check("t5_not_taken", {30'd0, in_ready, ser_clear}, 32'd3);

    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_mid_shift", {31'd0, ser_clear}, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_rst_ser_clear", {31'd0, ser_clear}, 32'd1);
    check("t6_rst_ser_ab", {30'd0, ser_a, ser_b}, 32'd0);
    check("t6_rst_out_sum", {23'd0, out_sum}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    shift_word(8'h12, 8'h34, "t6");
    take_result(9'h046, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
